vga_capture: RTL and testbench

- Receive side of the VGA link: samples hSync, vSync and 3-bit rgb on the pixel strobe and recovers pixel coordinates.
- Checks the incoming timing against the configured mode and declares lock.
- While locked, emits a stream of active-area pixels (x, y, rgb) for a frame checker or framebuffer writer.
- Used in loopback benches and board self-test, facing the sync/rgb pins the generator drives.

---
 rtl/vga_capture.sv | 266 ++++++++++++++++++++++++++
 tb/tb_vga_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA link.
// Samples hSync/vSync/rgb on the pixel strobe, recovers the raster position,
// checks the line/frame timing against the configured mode, declares lock,
// and while locked emits one (x, y, rgb) beat per active-area pixel.
//
// Pipeline:
//   stage 1 (pixEn edge): pin samples, hPos/vPos counters, lock FSM
//   stage 2 (next clk)  : active-area decode and registered pixel outputs
// so pixValid appears exactly two clocks after the pixEn cycle that sampled
// the pins.
module vga_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixEn,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [2:0]  rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [2:0]  pixRgb,
    output logic        pixValid,
    output logic        frameStart,
    output logic        locked,
    output logic        err,
    output logic [7:0]  errCnt,
    output logic [10:0] lineLen
);

    // Active window bounds and expected totals, sized to the counters they
    // are compared against.
    localparam logic [9:0]  H_START   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_END     = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam logic [9:0]  POS_MAX   = 10'h3FF;
    localparam logic [7:0]  CNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // ---------------------------------------------------------------
    // Stage 1 state
    // ---------------------------------------------------------------
    logic        hs_q;          // previous hSync sample
    logic        vs_q;          // previous vSync sample
    logic [2:0]  rgb_q;         // colour sampled with the current position
    logic [9:0]  h_pos_q,     h_pos_d;
    logic [9:0]  v_pos_q,     v_pos_d;
    logic        v_pend_q,    v_pend_d;     // vSync fell, waiting for hSync
    logic        seen_line_q, seen_line_d;  // a line start has been seen
    logic        seen_bnd_q,  seen_bnd_d;   // a frame boundary has been seen
    logic        frame_bad_q, frame_bad_d;  // a bad line occurred this frame
    logic [10:0] line_len_q,  line_len_d;

    // Lock FSM state and its registered outputs
    lock_state_e state_q;
    logic        locked_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    // Stage 2 state
    logic        tick_q;        // stage 1 advanced on the previous clk
    logic        pix_valid_q;
    logic        frame_start_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [2:0]  pix_rgb_q;

    // ---------------------------------------------------------------
    // Edge detection and line/frame qualification
    // ---------------------------------------------------------------
    logic        h_fall;
    logic        v_fall;
    logic        boundary;
    logic [10:0] h_len;
    logic [10:0] v_len;
    logic        line_ok;
    logic        frame_good;

    // A fall is previous sample high, current pin low, on a strobe only.
    assign h_fall = pixEn & hs_q & ~hSync;
    assign v_fall = pixEn & vs_q & ~vSync;

    // A frame boundary is the first line start at or after a vSync fall.
    assign boundary = h_fall & (v_pend_q | v_fall);

    // Lengths include the tick that ends the line/frame.
    assign h_len = {1'b0, h_pos_q} + 11'd1;
    assign v_len = {1'b0, v_pos_q} + 11'd1;

    // The very first line start after reset closes no real line.
    assign line_ok = seen_line_q & (h_len == H_TOTAL_L);

    // The line closed by the boundary belongs to the frame being judged.
    assign frame_good = seen_bnd_q & ~frame_bad_q & line_ok & (v_len == V_TOTAL_L);

    // Next-state for the position counters and frame bookkeeping.
    always_comb begin
        h_pos_d     = h_pos_q;
        v_pos_d     = v_pos_q;
        v_pend_d    = v_pend_q;
        seen_line_d = seen_line_q;
        seen_bnd_d  = seen_bnd_q;
        frame_bad_d = frame_bad_q;
        line_len_d  = line_len_q;
        if (pixEn) begin
            if (h_fall) begin
                h_pos_d     = '0;
                line_len_d  = h_len;
                seen_line_d = 1'b1;
            end else if (h_pos_q != POS_MAX) begin
                h_pos_d = h_pos_q + 10'd1;
            end

            if (boundary) begin
                v_pos_d     = '0;
                v_pend_d    = 1'b0;
                seen_bnd_d  = 1'b1;
                frame_bad_d = 1'b0;
            end else begin
                if (v_fall) begin
                    v_pend_d = 1'b1;
                end
                if (h_fall) begin
                    if (v_pos_q != POS_MAX) begin
                        v_pos_d = v_pos_q + 10'd1;
                    end
                    if (!line_ok) begin
                        frame_bad_d = 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1 registers: pin samples advance only on the pixel strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            rgb_q       <= '0;
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            v_pend_q    <= 1'b0;
            seen_line_q <= 1'b0;
            seen_bnd_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            line_len_q  <= '0;
        end else begin
            if (pixEn) begin
                hs_q  <= hSync;
                vs_q  <= vSync;
                rgb_q <= rgb;
            end
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            v_pend_q    <= v_pend_d;
            seen_line_q <= seen_line_d;
            seen_bnd_q  <= seen_bnd_d;
            frame_bad_q <= frame_bad_d;
            line_len_q  <= line_len_d;
        end
    end

    // Lock FSM: judged at every line start, frames judged at boundaries.
    // Only a loss from LOCKED raises err and bumps the saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (h_fall) begin
                case (state_q)
                    SEARCH: begin
                        if (boundary && frame_good) begin
                            state_q <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (boundary) begin
                            if (frame_good) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!line_ok || (boundary && !frame_good)) begin
                            state_q  <= SEARCH;
                            locked_q <= 1'b0;
                            err_q    <= 1'b1;
                            if (err_cnt_q != CNT_MAX) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: active-area decode on the clk after stage 1 advanced
    // ---------------------------------------------------------------
    logic in_active;
    logic emit;

    assign in_active = (h_pos_q >= H_START) && (h_pos_q < H_END) &&
                       (v_pos_q >= V_START) && (v_pos_q < V_END);
    assign emit      = tick_q & locked_q & in_active;

    // Pixel outputs: strobes pulse for one clk, payload holds between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q        <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pix_rgb_q     <= '0;
        end else begin
            tick_q        <= pixEn;
            pix_valid_q   <= emit;
            frame_start_q <= emit && (h_pos_q == H_START) && (v_pos_q == V_START);
            if (emit) begin
                x_q       <= h_pos_q - H_START;
                y_q       <= v_pos_q - V_START;
                pix_rgb_q <= rgb_q;
            end
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign pixRgb     = pix_rgb_q;
    assign pixValid   = pix_valid_q;
    assign frameStart = frame_start_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign errCnt     = err_cnt_q;
    assign lineLen    = line_len_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture, run with a shrunken video mode so whole frames fit
// in a short simulation. A generator drives the raster; every active pixel
// expected to be emitted is queued with its due cycle and compared when the
// DUT pulses pixValid.
module tb_vga_capture;

    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HA = 8;
    localparam int HT = 20;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VA = 4;
    localparam int VT = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixEn;
    logic        hSync;
    logic        vSync;
    logic [2:0]  rgb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  pixRgb;
    logic        pixValid;
    logic        frameStart;
    logic        locked;
    logic        err;
    logic [7:0]  errCnt;
    logic [10:0] lineLen;

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst(rst), .pixEn(pixEn), .hSync(hSync), .vSync(vSync),
        .rgb(rgb), .x(x), .y(y), .pixRgb(pixRgb), .pixValid(pixValid),
        .frameStart(frameStart), .locked(locked), .err(err),
        .errCnt(errCnt), .lineLen(lineLen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         due;
        logic       fs;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   cyc      = 0;
    int   pix_cnt  = 0;
    int   err_seen = 0;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe outputs on the falling edge, then drive inputs
    // that the DUT samples on the next rising edge.
    task automatic cycle(input logic en, input logic hs, input logic vs, input logic [2:0] c);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (err) err_seen++;
        if (frameStart && !pixValid) chk("fs_alone", 32'd1, 32'd0);
        if (pixValid) begin
            if (sb.size() == 0) begin
                chk("unexp_pix", {22'd0, x}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("pix", {8'd0, frameStart, x, y, pixRgb}, {8'd0, e.fs, e.ex, e.ey, e.c});
                chk("lat", cyc, e.due);
                pix_cnt++;
            end
        end
        pixEn = en;
        hSync = hs;
        vSync = vs;
        rgb   = c;
    endtask

    // One pixel period: a strobe followed by three idle clocks.
    task automatic pix(input logic hs, input logic vs, input logic [2:0] c,
                       input bit push, input int ex, input int ey);
        exp_t e;
        cycle(1'b1, hs, vs, c);
        if (push) begin
            e.due = cyc + 2;
            e.fs  = (ex == 0) && (ey == 0);
            e.ex  = 10'(ex);
            e.ey  = 10'(ey);
            e.c   = c;
            sb.push_back(e);
        end
        repeat (3) cycle(1'b0, hs, vs, c);
    endtask

    task automatic idle(input int n);
        repeat (n) pix(1'b1, 1'b1, 3'd0, 1'b0, 0, 0);
    endtask

    // One frame of nl lines; line sl (if >= 0) is one tick short; lk is the
    // lock state expected from the frame's opening boundary; stop (if >= 0)
    // abandons the frame before that line.
    task automatic frame(input int nl, input int sl, input bit lk, input int stop);
        int len;
        bit act;
        bit cur;
        logic [2:0] c;
        for (int l = 0; l < nl; l++) begin
            if (l == stop) break;
            len = (l == sl) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                act = (h >= HS + HB) && (h < HS + HB + HA) &&
                      (l >= VS + VB) && (l < VS + VB + VA);
                c   = act ? 3'((h - HS - HB + l - VS - VB) % 8) : 3'($urandom);
                cur = lk && !(sl >= 0 && l > sl);
                pix(1'(h >= HS), 1'(l >= VS), c, act && cur, h - HS - HB, l - VS - VB);
            end
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"},        {22'd0, x},        0);
        chk({tag, "_y"},        {22'd0, y},        0);
        chk({tag, "_rgb"},      {29'd0, pixRgb},   0);
        chk({tag, "_valid"},    {31'd0, pixValid}, 0);
        chk({tag, "_fstart"},   {31'd0, frameStart}, 0);
        chk({tag, "_locked"},   {31'd0, locked},   0);
        chk({tag, "_err"},      {31'd0, err},      0);
        chk({tag, "_errcnt"},   {24'd0, errCnt},   0);
        chk({tag, "_linelen"},  {21'd0, lineLen},  0);
    endtask

    initial begin
        rst = 1'b1; pixEn = 1'b0; hSync = 1'b1; vSync = 1'b1; rgb = 3'd0;
        repeat (4) cycle(1'b0, 1'b1, 1'b1, 3'd0);
        rst = 1'b0;
        check_zero("por");

        // Acquire lock: boundaries 1 and 2 do not lock, boundary 3 does.
        idle(4);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        chk("lock_pre", {31'd0, locked}, 0);
        pix_cnt = 0;
        frame(VT, -1, 1'b1, -1);
        chk("npix_f3", pix_cnt, HA * VA);
        chk("lock_f3", {31'd0, locked}, 1);
        chk("err_none", err_seen, 0);
        chk("errcnt_0", {24'd0, errCnt}, 0);
        chk("linelen", {21'd0, lineLen}, HT);
        pix_cnt = 0;
        frame(VT, -1, 1'b1, -1);
        chk("npix_f4", pix_cnt, HA * VA);

        // One short line while locked: output stops at the next line start.
        pix_cnt = 0;
        frame(VT, 5, 1'b1, -1);
        chk("npix_short", pix_cnt, 2 * HA);
        chk("lock_short", {31'd0, locked}, 0);
        chk("err_short", err_seen, 1);
        chk("errcnt_short", {24'd0, errCnt}, 1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        chk("lock_armed", {31'd0, locked}, 0);
        pix_cnt = 0;
        frame(VT, -1, 1'b1, -1);
        chk("npix_relock", pix_cnt, HA * VA);
        chk("lock_relock", {31'd0, locked}, 1);

        // Frame one line short: lock dropped at its closing boundary.
        pix_cnt = 0;
        frame(VT - 1, -1, 1'b1, -1);
        chk("npix_vshort", pix_cnt, HA * VA);
        chk("lock_vshort", {31'd0, locked}, 1);
        frame(VT, -1, 1'b0, -1);
        chk("err_vshort", err_seen, 2);
        chk("errcnt_vshort", {24'd0, errCnt}, 2);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b1, -1);
        chk("lock_relock2", {31'd0, locked}, 1);

        // Reset mid-frame for one clock.
        frame(VT, -1, 1'b1, 6);
        chk("lock_prerst", {31'd0, locked}, 1);
        chk("x_prerst", {22'd0, x}, HA - 1);
        cycle(1'b0, 1'b1, 1'b1, 3'd0);
        rst = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 3'd0);
        rst = 1'b0;
        check_zero("midrst");
        idle(4);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        chk("lock_rst2", {31'd0, locked}, 0);
        frame(VT, -1, 1'b1, -1);
        chk("lock_rst3", {31'd0, locked}, 1);
        chk("errcnt_rst", {24'd0, errCnt}, 0);

        // hSync held low far beyond the counter range.
        repeat (2000) pix(1'b0, 1'b1, 3'($urandom), 1'b0, 0, 0);
        repeat (10) pix(1'b1, 1'b1, 3'($urandom), 1'b0, 0, 0);
        pix(1'b0, 1'b1, 3'd0, 1'b0, 0, 0);
        chk("linelen_sat", {21'd0, lineLen}, 1024);
        chk("lock_sat", {31'd0, locked}, 0);
        chk("err_sat", err_seen, 3);
        chk("errcnt_sat", {24'd0, errCnt}, 1);

        // Pins wiggle with no strobe: nothing may move.
        repeat (200) cycle(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
        chk("hold_linelen", {21'd0, lineLen}, 1024);
        chk("hold_x", {22'd0, x}, HA - 1);
        chk("hold_y", {22'd0, y}, VA - 1);
        chk("hold_rgb", {29'd0, pixRgb}, (HA - 1 + VA - 1) % 8);
        chk("hold_errcnt", {24'd0, errCnt}, 1);
        chk("hold_err", err_seen, 3);
        // Position counting resumes from where the last strobe left it.
        repeat (3) pix(1'b0, 1'b1, 3'd0, 1'b0, 0, 0);
        repeat (2) pix(1'b1, 1'b1, 3'd0, 1'b0, 0, 0);
        pix(1'b0, 1'b1, 3'd0, 1'b0, 0, 0);
        chk("hold_resume", {21'd0, lineLen}, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
